// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack port, stalls
// execute while an access is outstanding, and registers results into WB.
module mem_stage #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] next_pc_mem,
   input  logic [31:0] alu_result_mem,
   input  logic [31:0] write_data_mem,
   input  logic [1:0]  wb_sel_mem,
   input  logic [1:0]  read_width_mem,
   input  logic [4:0]  wrt_dst_mem,
   input  logic        mem_wrt_en_mem,
   input  logic        reg_wrt_en_mem,
   input  logic        read_unsigned_mem,
   input  logic        rd_en_mem,
   output logic        stall_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] next_pc_wb,
   output logic [31:0] alu_result_wb,
   output logic [31:0] mem_data_wb,
   output logic [1:0]  wb_sel_wb,
   output logic [4:0]  wrt_dst_wb,
   output logic        reg_wrt_en_wb,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CntW-1:0] LastCnt = (TIMEOUT > 0) ? CntW'(TIMEOUT - 1) : '0;

   typedef enum logic [0:0] {StIdle, StWait} state_t;

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Copies of the request taken while idle; they drive the port during WAIT.
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic        we_q, uns_q;
   logic [1:0]  width_q;

   logic        access, misalign, timeout_hit;
   logic [3:0]  be_calc;
   logic [31:0] wdata_calc;
   logic        wb_load, wb_bubble, set_misalign, set_bus;
   logic [31:0] load_data;

   // Pick the addressed lane and sign/zero-extend it.
   function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [1:0] off,
                                           input logic [1:0] width, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{off, 3'b000} +: 8];
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (width)
         2'b00:   extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: extract = rdata;
      endcase
   endfunction

   // Decode access, alignment and store lane placement from the MEM inputs.
   always_comb begin
      access   = rd_en_mem | mem_wrt_en_mem;
      misalign = access & (((read_width_mem == 2'b01) & alu_result_mem[0]) |
                           (read_width_mem[1] & (alu_result_mem[1:0] != 2'b00)));
      be_calc    = 4'b1111;
      wdata_calc = write_data_mem;
      if (mem_wrt_en_mem) begin
         case (read_width_mem)
            2'b00: begin
               be_calc    = 4'b0001 << alu_result_mem[1:0];
               wdata_calc = {4{write_data_mem[7:0]}};
            end
            2'b01: begin
               be_calc    = alu_result_mem[1] ? 4'b1100 : 4'b0011;
               wdata_calc = {2{write_data_mem[15:0]}};
            end
            default: be_calc = 4'b1111;
         endcase
      end
      timeout_hit = (TIMEOUT != 0) && (cnt_q == LastCnt);
   end

   // Next state, port drive and WB update control.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stall_mem    = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = mem_wrt_en_mem;
      dmem_addr    = {alu_result_mem[31:2], 2'b00};
      dmem_be      = be_calc;
      dmem_wdata   = wdata_calc;
      wb_load      = 1'b0;
      wb_bubble    = 1'b0;
      set_misalign = 1'b0;
      set_bus      = 1'b0;
      load_data    = 32'h0;
      unique case (state_q)
         StIdle: begin
            if (misalign) begin
               set_misalign = 1'b1;
               wb_bubble    = 1'b1;
            end else if (access) begin
               dmem_req  = 1'b1;
               stall_mem = 1'b1;
               wb_bubble = 1'b1;
               cnt_d     = '0;
               state_d   = StWait;
            end else begin
               wb_load = 1'b1;
            end
         end
         StWait: begin
            dmem_req   = 1'b1;
            dmem_we    = we_q;
            dmem_addr  = {addr_q[31:2], 2'b00};
            dmem_be    = be_q;
            dmem_wdata = wdata_q;
            if (dmem_ack) begin
               wb_load   = 1'b1;
               load_data = we_q ? 32'h0 : extract(dmem_rdata, addr_q[1:0], width_q, uns_q);
               state_d   = StIdle;
            end else if (timeout_hit) begin
               set_bus   = 1'b1;
               wb_bubble = 1'b1;
               state_d   = StIdle;
            end else begin
               stall_mem = 1'b1;
               cnt_d     = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State, request copies, WB registers and error pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         addr_q        <= 32'h0;
         wdata_q       <= 32'h0;
         be_q          <= 4'h0;
         we_q          <= 1'b0;
         uns_q         <= 1'b0;
         width_q       <= 2'b00;
         next_pc_wb    <= 32'h0;
         alu_result_wb <= 32'h0;
         mem_data_wb   <= 32'h0;
         wb_sel_wb     <= 2'b00;
         wrt_dst_wb    <= 5'h0;
         reg_wrt_en_wb <= 1'b0;
         misalign_err  <= 1'b0;
         bus_err       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         misalign_err <= set_misalign;
         bus_err      <= set_bus;
         if (state_q == StIdle) begin
            addr_q  <= alu_result_mem;
            wdata_q <= wdata_calc;
            be_q    <= be_calc;
            we_q    <= mem_wrt_en_mem;
            uns_q   <= read_unsigned_mem;
            width_q <= read_width_mem;
         end
         if (wb_load | wb_bubble) begin
            next_pc_wb    <= next_pc_mem;
            alu_result_wb <= alu_result_mem;
            wb_sel_wb     <= wb_sel_mem;
            wrt_dst_wb    <= wrt_dst_mem;
            reg_wrt_en_wb <= wb_load & reg_wrt_en_mem;
            mem_data_wb   <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (TIMEOUT=4).
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] next_pc_mem, alu_result_mem, write_data_mem;
   logic [1:0]  wb_sel_mem, read_width_mem;
   logic [4:0]  wrt_dst_mem;
   logic        mem_wrt_en_mem, reg_wrt_en_mem, read_unsigned_mem, rd_en_mem;
   logic        stall_mem, dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [31:0] next_pc_wb, alu_result_wb, mem_data_wb;
   logic [1:0]  wb_sel_wb;
   logic [4:0]  wrt_dst_wb;
   logic        reg_wrt_en_wb, misalign_err, bus_err;

   int n_tests = 0;
   int n_fail  = 0;

   mem_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .next_pc_mem(next_pc_mem), .alu_result_mem(alu_result_mem),
      .write_data_mem(write_data_mem), .wb_sel_mem(wb_sel_mem),
      .read_width_mem(read_width_mem), .wrt_dst_mem(wrt_dst_mem),
      .mem_wrt_en_mem(mem_wrt_en_mem), .reg_wrt_en_mem(reg_wrt_en_mem),
      .read_unsigned_mem(read_unsigned_mem), .rd_en_mem(rd_en_mem),
      .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .next_pc_wb(next_pc_wb), .alu_result_wb(alu_result_wb), .mem_data_wb(mem_data_wb),
      .wb_sel_wb(wb_sel_wb), .wrt_dst_wb(wrt_dst_wb), .reg_wrt_en_wb(reg_wrt_en_wb),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; returns 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle_inputs();
      next_pc_mem = 32'h0; alu_result_mem = 32'h0; write_data_mem = 32'h0;
      wb_sel_mem = 2'b00; read_width_mem = 2'b00; wrt_dst_mem = 5'd0;
      mem_wrt_en_mem = 1'b0; reg_wrt_en_mem = 1'b0; read_unsigned_mem = 1'b0;
      rd_en_mem = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
   endtask

   task automatic load(input logic [31:0] addr, input logic [1:0] width, input logic uns,
                       input logic [4:0] rd);
      idle_inputs();
      alu_result_mem = addr; read_width_mem = width; read_unsigned_mem = uns;
      rd_en_mem = 1'b1; reg_wrt_en_mem = 1'b1; wrt_dst_mem = rd; next_pc_mem = 32'h100;
   endtask

   initial begin
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      // Reset state
      chk("rst_stall", stall_mem, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_alu_wb", alu_result_wb, 0);
      chk("rst_regwe_wb", reg_wrt_en_wb, 0);
      chk("rst_bus_err", bus_err, 0);
      rst = 1'b0;

      // Non-memory op
      alu_result_mem = 32'h1234; reg_wrt_en_mem = 1'b1; wrt_dst_mem = 5'd5;
      next_pc_mem = 32'h44; wb_sel_mem = 2'b01;
      #1;
      chk("alu_req", dmem_req, 0);
      chk("alu_stall", stall_mem, 0);
      tick();
      chk("alu_result_wb", alu_result_wb, 32'h1234);
      chk("alu_regwe_wb", reg_wrt_en_wb, 1);
      chk("alu_dst_wb", wrt_dst_wb, 5);
      chk("alu_pc_wb", next_pc_wb, 32'h44);
      chk("alu_sel_wb", wb_sel_wb, 1);

      // LB 0x103, ack three cycles after req
      load(32'h103, 2'b00, 1'b0, 5'd7);
      #1;
      chk("lb_req_c0", dmem_req, 1);
      chk("lb_stall_c0", stall_mem, 1);
      chk("lb_addr", dmem_addr, 32'h100);
      chk("lb_be", dmem_be, 4'hF);
      chk("lb_we", dmem_we, 0);
      tick();
      chk("lb_stall_c1", stall_mem, 1);
      chk("lb_bubble", reg_wrt_en_wb, 0);
      tick();
      chk("lb_stall_c2", stall_mem, 1);
      chk("lb_addr_c2", dmem_addr, 32'h100);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'h80AABBCC;
      #1;
      chk("lb_stall_ack", stall_mem, 0);
      chk("lb_req_ack", dmem_req, 1);
      tick();
      chk("lb_data", mem_data_wb, 32'hFFFFFF80);
      chk("lb_regwe_wb", reg_wrt_en_wb, 1);
      chk("lb_dst_wb", wrt_dst_wb, 7);

      // LBU 0x103, ack next cycle
      load(32'h103, 2'b00, 1'b1, 5'd8);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'h80AABBCC;
      tick();
      chk("lbu_data", mem_data_wb, 32'h00000080);

      // LH 0x102 (signed upper half)
      load(32'h102, 2'b01, 1'b0, 5'd9);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'h80AABBCC;
      tick();
      chk("lh_data", mem_data_wb, 32'hFFFF80AA);

      // LW 0x104 passes the word unchanged
      load(32'h104, 2'b10, 1'b0, 5'd10);
      tick();
      dmem_ack = 1'b1; dmem_rdata = 32'h80AABBCC;
      tick();
      chk("lw_data", mem_data_wb, 32'h80AABBCC);

      // SH 0x202, ack next cycle; store data changed mid-access must not leak out
      idle_inputs();
      alu_result_mem = 32'h202; write_data_mem = 32'h0000BEEF; read_width_mem = 2'b01;
      mem_wrt_en_mem = 1'b1;
      #1;
      chk("sh_we", dmem_we, 1);
      chk("sh_be", dmem_be, 4'b1100);
      chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
      chk("sh_addr", dmem_addr, 32'h200);
      chk("sh_stall_c0", stall_mem, 1);
      tick();
      write_data_mem = 32'h0; dmem_ack = 1'b1;
      #1;
      chk("sh_stall_c1", stall_mem, 0);
      chk("sh_wdata_held", dmem_wdata, 32'hBEEFBEEF);
      chk("sh_be_held", dmem_be, 4'b1100);
      tick();
      chk("sh_regwe_wb", reg_wrt_en_wb, 0);
      chk("sh_data_wb", mem_data_wb, 0);

      // SB 0x201 lane placement
      idle_inputs();
      alu_result_mem = 32'h201; write_data_mem = 32'h1234565A; mem_wrt_en_mem = 1'b1;
      #1;
      chk("sb_be", dmem_be, 4'b0010);
      chk("sb_wdata", dmem_wdata, 32'h5A5A5A5A);
      tick();
      dmem_ack = 1'b1;
      tick();

      // Misaligned LW 0x106
      load(32'h106, 2'b10, 1'b0, 5'd11);
      #1;
      chk("mis_req", dmem_req, 0);
      chk("mis_stall", stall_mem, 0);
      tick();
      chk("mis_err", misalign_err, 1);
      chk("mis_regwe_wb", reg_wrt_en_wb, 0);
      idle_inputs();
      tick();
      chk("mis_err_pulse", misalign_err, 0);

      // LW with no ack: TIMEOUT=4 gives four stall cycles, then bus_err
      load(32'h300, 2'b10, 1'b0, 5'd12);
      #1;
      chk("to_stall_c0", stall_mem, 1);
      tick();
      chk("to_stall_c1", stall_mem, 1);
      tick();
      chk("to_stall_c2", stall_mem, 1);
      tick();
      chk("to_stall_c3", stall_mem, 1);
      tick();
      chk("to_stall_c4", stall_mem, 0);
      chk("to_req_c4", dmem_req, 1);
      tick();
      // Pipeline advances: next instruction is an ALU op
      idle_inputs();
      alu_result_mem = 32'h5555; reg_wrt_en_mem = 1'b1; wrt_dst_mem = 5'd3;
      #1;
      chk("to_bus_err", bus_err, 1);
      chk("to_req_drop", dmem_req, 0);
      chk("to_bubble", reg_wrt_en_wb, 0);
      tick();
      chk("to_bus_pulse", bus_err, 0);
      chk("to_alu_wb", alu_result_wb, 32'h5555);
      chk("to_alu_regwe", reg_wrt_en_wb, 1);

      // Reset during WAIT, then a late ack
      load(32'h400, 2'b10, 1'b0, 5'd13);
      tick();
      chk("rw_stall", stall_mem, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      chk("rw_req", dmem_req, 0);
      chk("rw_stall_after", stall_mem, 0);
      chk("rw_alu_wb", alu_result_wb, 0);
      chk("rw_pc_wb", next_pc_wb, 0);
      chk("rw_dst_wb", wrt_dst_wb, 0);
      tick();
      chk("rw_late_ack_data", mem_data_wb, 0);
      chk("rw_late_ack_regwe", reg_wrt_en_wb, 0);
      chk("rw_late_ack_req", dmem_req, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
